// File: rtl/smem_pkg.sv
// Shared definitions for the SMEM result-path arbiter: line width, state
// encodings and the downstream almost-full slack.
package smem_pkg;

  localparam int CL       = 512;
  localparam int AF_SLACK = 3;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_GRANT  = 4'b0010,
    ST_SWITCH = 4'b0100,
    ST_DONE   = 4'b1000
  } arb_state_e;

endpackage

// File: rtl/smem_output_arbiter_rr_pick.sv
// Round-robin picker: first set bit of eligible at or after rr_ptr, wrapping
// modulo NUM_SRC. Purely combinational.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic [SRC_W-1:0]   idx,
  output logic               found
);

  logic [SRC_W-1:0]   w_pos [NUM_SRC];
  logic [NUM_SRC-1:0] w_rot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_rot
      logic [SRC_W:0] w_sum;
      // rr_ptr + gi never exceeds 2*NUM_SRC-2, so one subtraction wraps it.
      assign w_sum      = {1'b0, rr_ptr} + (SRC_W+1)'(gi);
      assign w_pos[gi]  = (w_sum >= (SRC_W+1)'(NUM_SRC)) ?
                          SRC_W'(w_sum - (SRC_W+1)'(NUM_SRC)) : w_sum[SRC_W-1:0];
      assign w_rot[gi]  = eligible[w_pos[gi]];
    end
  endgenerate

  always_comb begin
    found = |w_rot;
    idx   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) idx = w_pos[k];
    end
  end

endmodule

// File: rtl/smem_output_arbiter.sv
// Shares one result write channel between NUM_SRC pipelines: round-robin grant
// held until the granted source finishes, registered capture and stall.
module smem_output_arbiter
  import smem_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2,
  parameter int DATA_W  = CL
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      batch_start,
  input  logic [NUM_SRC-1:0]        src_request,
  output logic [NUM_SRC-1:0]        src_permit,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_finish,
  output logic                      stall,
  input  logic                      out_almost_full,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic [SRC_W-1:0]          out_src,
  output logic                      all_done
);

  arb_state_e         r_state, w_state_next;
  logic [SRC_W-1:0]   r_cur, w_cur_next;
  logic [SRC_W-1:0]   r_rr_ptr, w_rr_ptr_next;
  logic [NUM_SRC-1:0] r_done_mask, w_done_mask_next;

  logic               r_stall;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [SRC_W-1:0]   r_out_src;

  logic [NUM_SRC-1:0] w_eligible;
  logic [SRC_W-1:0]   w_pick_idx;
  logic               w_pick_found;
  logic               w_all_finished;
  logic [SRC_W-1:0]   w_cur_inc;
  logic [NUM_SRC-1:0] w_cur_oh;
  logic               w_capture;
  logic [DATA_W-1:0]  w_src_data [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_src_data[gi] = src_data[gi*DATA_W +: DATA_W];
      assign w_cur_oh[gi]   = (r_cur == SRC_W'(gi));
    end
  endgenerate

  assign w_eligible     = src_request & ~r_done_mask;
  assign w_all_finished = &r_done_mask;
  assign w_cur_inc      = (r_cur == SRC_W'(NUM_SRC - 1)) ? '0 : r_cur + 1'b1;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .eligible (w_eligible),
    .rr_ptr   (r_rr_ptr),
    .idx      (w_pick_idx),
    .found    (w_pick_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cur       <= '0;
      r_rr_ptr    <= '0;
      r_done_mask <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cur       <= w_cur_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_done_mask <= w_done_mask_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cur_next       = r_cur;
    w_rr_ptr_next    = r_rr_ptr;
    w_done_mask_next = r_done_mask;
    case (r_state)
      ST_IDLE: begin
        if (w_all_finished) begin
          w_state_next = ST_DONE;
        end else if (w_pick_found) begin
          w_cur_next   = w_pick_idx;
          w_state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Only the granted source's finish ends the grant; others are ignored.
        if (src_finish[r_cur] && !r_stall) begin
          w_done_mask_next[r_cur] = 1'b1;
          w_rr_ptr_next           = w_cur_inc;
          w_state_next            = ST_SWITCH;
        end
      end
      ST_SWITCH: w_state_next = ST_IDLE;
      ST_DONE:   w_state_next = ST_DONE;
      default:   w_state_next = ST_IDLE;
    endcase
    // A new batch restarts arbitration but keeps the round-robin position.
    if (batch_start) begin
      w_state_next     = ST_IDLE;
      w_cur_next       = r_cur;
      w_rr_ptr_next    = r_rr_ptr;
      w_done_mask_next = '0;
    end
  end

  always_comb begin
    src_permit = '0;
    all_done   = 1'b0;
    if (r_state == ST_GRANT) src_permit = w_cur_oh;
    if (r_state == ST_DONE)  all_done   = 1'b1;
  end

  assign w_capture = (r_state == ST_GRANT) && src_valid[r_cur] && !r_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else begin
      r_stall     <= out_almost_full;
      r_out_valid <= w_capture;
      r_out_data  <= w_src_data[r_cur];
      r_out_src   <= r_cur;
    end
  end

  assign stall     = r_stall;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_smem_output_arbiter.sv
// Directed bench for smem_output_arbiter: behavioural sources react to permit
// and stall; a negedge monitor logs every write and every grant.
module tb_smem_output_arbiter;
  import smem_pkg::*;

  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int DW  = 512;
  localparam int TMO = 200;

  logic            clk = 1'b0;
  logic            reset;
  logic            batch_start;
  logic [N-1:0]    src_request;
  logic [N-1:0]    src_permit;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_finish;
  logic            stall;
  logic            out_almost_full;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic [SW-1:0]   out_src;
  logic            all_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] obs_data [$];
  int            obs_src  [$];
  int            grant_q  [$];
  int            gap_q    [$];
  int            zero_run = 0;
  int            oh_err   = 0;
  logic [N-1:0]  prev_permit = '0;

  smem_output_arbiter #(.NUM_SRC(N), .SRC_W(SW), .DATA_W(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .batch_start     (batch_start),
    .src_request     (src_request),
    .src_permit      (src_permit),
    .src_data        (src_data),
    .src_valid       (src_valid),
    .src_finish      (src_finish),
    .stall           (stall),
    .out_almost_full (out_almost_full),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_src         (out_src),
    .all_done        (all_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    int gidx;
    if (out_valid) begin
      obs_data.push_back(out_data);
      obs_src.push_back(int'(out_src));
      $display("[%0t] write src=%0d data=%h", $time, out_src, out_data[31:0]);
    end
    if (src_permit != '0 && prev_permit == '0) begin
      gidx = 0;
      for (int k = 0; k < N; k++) if (src_permit[k]) gidx = k;
      grant_q.push_back(gidx);
      gap_q.push_back(zero_run);
      $display("[%0t] grant src=%0d after %0d idle cycles", $time, gidx, zero_run);
    end
    if ($countones(src_permit) > 1) oh_err++;
    zero_run    = (src_permit == '0) ? zero_run + 1 : 0;
    prev_permit = src_permit;
  end

  function automatic int grant_code();
    int acc = 0;
    foreach (grant_q[i]) acc = acc * 10 + grant_q[i] + 1;
    return acc;
  endfunction

  task automatic set_word(input int g, input logic [31:0] w);
    src_data[g*DW +: DW] = {16{w}};
  endtask

  task automatic clear_logs();
    obs_data.delete();
    obs_src.delete();
    grant_q.delete();
    gap_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_request = '0; src_valid = '0; src_finish = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Source model: waits for its permit, streams n words (holding while stall),
  // then raises finish and releases once the permit drops.
  task automatic serve(input int s, input int n, input logic [31:0] base);
    int   t;
    int   g;
    int   idx;
    logic pend_stall;
    t = 0;
    while (src_permit == '0 && t < TMO) begin @(negedge clk); t++; end
    n_checks++;
    if (src_permit !== (N'(1) << s))
      $display("FAIL grant_src%0d: permit=%b required %b", s, src_permit, N'(1) << s);
    else n_pass++;
    if (src_permit == '0) return;
    g = 0;
    for (int k = 0; k < N; k++) if (src_permit[k]) g = k;
    src_valid[g] = 1'b1;
    set_word(g, base);
    pend_stall = stall;
    idx = 0;
    t = 0;
    while (idx < n && t < TMO) begin
      @(negedge clk); t++;
      if (!pend_stall) idx++;
      if (idx < n) set_word(g, base + 32'(idx));
      else src_valid[g] = 1'b0;
      pend_stall = stall;
    end
    src_valid[g]  = 1'b0;
    src_finish[g] = 1'b1;
    t = 0;
    while (src_permit[g] && t < TMO) begin @(negedge clk); t++; end
    n_checks++;
    if (src_permit[g] !== 1'b0) $display("FAIL release_src%0d: permit still %b required 0", g, src_permit[g]);
    else n_pass++;
    src_finish[g]  = 1'b0;
    src_request[g] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; batch_start = 1'b0; out_almost_full = 1'b0;
    src_request = '0; src_valid = '0; src_finish = '0; src_data = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (src_permit !== '0) $display("FAIL rst_permit: got %b required 0", src_permit); else n_pass++;
    n_checks++; if (stall !== 1'b1) $display("FAIL rst_stall: got %b required 1", stall); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL rst_out_data: got %h required 0", out_data[31:0]); else n_pass++;
    n_checks++; if (out_src !== '0) $display("FAIL rst_out_src: got %0d required 0", out_src); else n_pass++;
    n_checks++; if (all_done !== 1'b0) $display("FAIL rst_all_done: got %b required 0", all_done); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL rst_release_stall: got %b required 0", stall); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    clear_logs();
    src_request = 4'b1111;
    serve(0, 2, 32'h100);
    serve(1, 2, 32'h110);
    serve(2, 2, 32'h120);
    serve(3, 2, 32'h130);
    n_checks++; if (all_done !== 1'b0) $display("FAIL rr_done_switch: got %b required 0", all_done); else n_pass++;
    @(negedge clk);
    n_checks++; if (all_done !== 1'b0) $display("FAIL rr_done_idle: got %b required 0", all_done); else n_pass++;
    @(negedge clk);
    n_checks++; if (all_done !== 1'b1) $display("FAIL rr_done_set: got %b required 1", all_done); else n_pass++;
    n_checks++; if (grant_code() !== 1234) $display("FAIL rr_order: code %0d required 1234", grant_code()); else n_pass++;
    // Between grants: the SWITCH gap plus the IDLE arbitration cycle.
    for (int i = 1; i < gap_q.size(); i++) begin
      n_checks++;
      if (gap_q[i] !== 2) $display("FAIL rr_gap%0d: got %0d required 2", i, gap_q[i]); else n_pass++;
    end
    n_checks++; if (obs_data.size() !== 8) $display("FAIL rr_count: got %0d required 8", obs_data.size()); else n_pass++;
    for (int i = 0; i < obs_data.size() && i < 8; i++) begin
      n_checks++;
      if (obs_src[i] !== i / 2 || obs_data[i] !== {16{32'(32'h100 + 16 * (i / 2) + i % 2)}})
        $display("FAIL rr_word%0d: src %0d data %h required src %0d data %h", i, obs_src[i],
                 obs_data[i][31:0], i / 2, 32'h100 + 16 * (i / 2) + i % 2);
      else n_pass++;
    end
  endtask

  task automatic test_single_source();
    n_checks++; if (all_done !== 1'b1) $display("FAIL single_pre_done: got %b required 1", all_done); else n_pass++;
    batch_start = 1'b1;
    @(negedge clk);
    batch_start = 1'b0;
    n_checks++; if (all_done !== 1'b0) $display("FAIL single_batch_clear: got %b required 0", all_done); else n_pass++;
    clear_logs();
    src_request[2] = 1'b1;
    serve(2, 3, 32'hA);
    repeat (4) @(negedge clk);
    n_checks++; if (all_done !== 1'b0) $display("FAIL single_all_done: got %b required 0", all_done); else n_pass++;
    n_checks++; if (src_permit !== '0) $display("FAIL single_permit_idle: got %b required 0", src_permit); else n_pass++;
    n_checks++; if (grant_code() !== 3) $display("FAIL single_order: code %0d required 3", grant_code()); else n_pass++;
    n_checks++; if (obs_data.size() !== 3) $display("FAIL single_count: got %0d required 3", obs_data.size()); else n_pass++;
    for (int i = 0; i < obs_data.size() && i < 3; i++) begin
      n_checks++;
      if (obs_src[i] !== 2 || obs_data[i] !== {16{32'(32'hA + i)}})
        $display("FAIL single_word%0d: src %0d data %h required src 2 data %h", i, obs_src[i],
                 obs_data[i][31:0], 32'hA + i);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    int   t;
    int   further;
    int   bad;
    logic prev_st;
    clear_logs();
    src_request[1] = 1'b1;
    fork
      serve(1, 8, 32'h200);
      begin
        t = 0;
        while (!src_permit[1] && t < TMO) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        out_almost_full = 1'b1;
        prev_st = stall;
        further = 0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (k == 0) begin
            n_checks++; if (stall !== 1'b1) $display("FAIL stall_rise: got %b required 1", stall); else n_pass++;
          end
          if (out_valid) further++;
          if (prev_st && out_valid) bad++;
          prev_st = stall;
          if (k == 4) out_almost_full = 1'b0;
        end
        n_checks++; if (further > AF_SLACK) $display("FAIL stall_slack: %0d writes after almost_full, limit %0d", further, AF_SLACK); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL stall_write: %0d writes while stalled, required 0", bad); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL stall_fall: got %b required 0", stall); else n_pass++;
      end
    join
    n_checks++; if (grant_code() !== 2) $display("FAIL stall_order: code %0d required 2", grant_code()); else n_pass++;
    n_checks++; if (obs_data.size() !== 8) $display("FAIL stall_count: got %0d required 8", obs_data.size()); else n_pass++;
    for (int i = 0; i < obs_data.size() && i < 8; i++) begin
      n_checks++;
      if (obs_src[i] !== 1 || obs_data[i] !== {16{32'(32'h200 + i)}})
        $display("FAIL stall_word%0d: src %0d data %h required src 1 data %h", i, obs_src[i],
                 obs_data[i][31:0], 32'h200 + i);
      else n_pass++;
    end
  endtask

  task automatic test_ignored_finish();
    clear_logs();
    src_request   = 4'b1001;
    src_finish[0] = 1'b1;
    serve(3, 3, 32'h300);
    src_finish[0] = 1'b0;
    serve(0, 2, 32'h310);
    n_checks++; if (grant_code() !== 41) $display("FAIL ign_order: code %0d required 41", grant_code()); else n_pass++;
    n_checks++; if (obs_data.size() !== 5) $display("FAIL ign_count: got %0d required 5", obs_data.size()); else n_pass++;
    for (int i = 0; i < obs_data.size() && i < 5; i++) begin
      n_checks++;
      if (obs_src[i] !== ((i < 3) ? 3 : 0) ||
          obs_data[i] !== {16{32'((i < 3) ? 32'h300 + i : 32'h310 + i - 3)}})
        $display("FAIL ign_word%0d: src %0d data %h", i, obs_src[i], obs_data[i][31:0]);
      else n_pass++;
    end
    repeat (2) @(negedge clk);
    n_checks++; if (all_done !== 1'b1) $display("FAIL ign_all_done: got %b required 1", all_done); else n_pass++;
  endtask

  task automatic test_batch_restart();
    n_checks++; if (all_done !== 1'b1) $display("FAIL batch_pre_done: got %b required 1", all_done); else n_pass++;
    batch_start = 1'b1;
    @(negedge clk);
    batch_start = 1'b0;
    n_checks++; if (all_done !== 1'b0) $display("FAIL batch_clear: got %b required 0", all_done); else n_pass++;
    n_checks++; if (src_permit !== '0) $display("FAIL batch_permit: got %b required 0", src_permit); else n_pass++;
    clear_logs();
    src_request = 4'b0101;
    serve(2, 2, 32'h400);
    serve(0, 2, 32'h410);
    repeat (4) @(negedge clk);
    // rr_ptr was left at 1 by the previous batch, so src2 precedes src0.
    n_checks++; if (grant_code() !== 31) $display("FAIL batch_order: code %0d required 31", grant_code()); else n_pass++;
    n_checks++; if (obs_data.size() !== 4) $display("FAIL batch_count: got %0d required 4", obs_data.size()); else n_pass++;
    n_checks++; if (all_done !== 1'b0) $display("FAIL batch_partial_done: got %b required 0", all_done); else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    int t;
    clear_logs();
    src_request = 4'b0011;
    t = 0;
    while (!src_permit[1] && t < TMO) begin @(negedge clk); t++; end
    n_checks++; if (src_permit !== 4'b0010) $display("FAIL mid_grant: got %b required 0010", src_permit); else n_pass++;
    src_valid[1] = 1'b1;
    set_word(1, 32'h500);
    @(negedge clk);
    set_word(1, 32'h501);
    @(negedge clk);
    set_word(1, 32'h502);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (src_permit !== '0) $display("FAIL mid_permit: got %b required 0", src_permit); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b required 0", out_valid); else n_pass++;
    n_checks++; if (stall !== 1'b1) $display("FAIL mid_stall: got %b required 1", stall); else n_pass++;
    reset = 1'b0;
    src_valid = '0;
    src_finish = '0;
    clear_logs();
    serve(0, 1, 32'h510);
    serve(1, 1, 32'h520);
    n_checks++; if (grant_code() !== 12) $display("FAIL mid_order: code %0d required 12", grant_code()); else n_pass++;
    n_checks++;
    if (obs_data.size() !== 2 || obs_src[0] !== 0 || obs_data[0] !== {16{32'h510}} ||
        obs_src[1] !== 1 || obs_data[1] !== {16{32'h520}})
      $display("FAIL mid_words: %0d words logged, required 0x510 from src0 then 0x520 from src1", obs_data.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_source();
    test_stall();
    test_ignored_finish();
    test_batch_restart();
    test_reset_mid_stream();
    n_checks++; if (oh_err !== 0) $display("FAIL permit_onehot: %0d cycles with multiple permits, required 0", oh_err); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
